// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient bank scheduler.
package fir_pkg;

  localparam int unsigned NTAPS_DEF  = 32;
  localparam int unsigned COEF_W_DEF = 16;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SWAP = 2'd2,
    FILL = 2'd3
  } state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Two-bank coefficient array: shadow write port, active->shadow copy port,
// registered read port from the active bank.
module fir_coef_bank #(
  parameter int unsigned NTAPS  = fir_pkg::NTAPS_DEF,
  parameter int unsigned COEF_W = fir_pkg::COEF_W_DEF,
  parameter int unsigned AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              cp_en,
  input  logic              cp_src,
  input  logic [AW-1:0]     cp_addr,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem [2][NTAPS];

  // Shadow writes only happen in IDLE and copies only in FILL, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end else if (cp_en) begin
      mem[~cp_src][cp_addr] <= mem[cp_src][cp_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/fir_coef_sched.sv
// Bank-swap scheduler: arms on commit, swaps on a sample boundary, then
// refills the delay line while copying the new active bank into the shadow.
module fir_coef_sched
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS  = NTAPS_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              commit,
  output logic              commit_err,
  input  logic              in_valid,
  input  logic [AW-1:0]     coef_rd_addr,
  output logic [COEF_W-1:0] coef_rd_data,
  output logic              fir_flush,
  output logic              out_en,
  output logic              bank_sel,
  output logic              busy,
  output logic [7:0]        swap_cnt
);

  localparam int unsigned CW = AW + 1;

  state_e        state, state_nx;
  logic [CW-1:0] smp_cnt, smp_cnt_nx;
  logic [CW-1:0] cp_idx, cp_idx_nx;
  logic          wr_en_c;
  logic          cp_en_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      smp_cnt <= '0;
      cp_idx  <= '0;
    end else begin
      state   <= state_nx;
      smp_cnt <= smp_cnt_nx;
      cp_idx  <= cp_idx_nx;
    end
  end

  // Exit from FILL looks at next-cycle counts so IDLE follows the last strobe directly.
  always_comb begin
    state_nx   = state;
    smp_cnt_nx = smp_cnt;
    cp_idx_nx  = cp_idx;
    wr_en_c    = 1'b0;
    cp_en_c    = 1'b0;
    case (state)
      IDLE: begin
        wr_en_c = cfg_valid;
        if (commit) state_nx = ARM;
      end
      ARM: begin
        if (in_valid) state_nx = SWAP;
      end
      SWAP: begin
        smp_cnt_nx = '0;
        cp_idx_nx  = '0;
        state_nx   = FILL;
      end
      FILL: begin
        if (in_valid && (smp_cnt != CW'(NTAPS))) smp_cnt_nx = smp_cnt + CW'(1);
        if (cp_idx != CW'(NTAPS)) begin
          cp_en_c   = 1'b1;
          cp_idx_nx = cp_idx + CW'(1);
        end
        if ((smp_cnt_nx == CW'(NTAPS)) && (cp_idx_nx == CW'(NTAPS))) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
      fir_flush  <= 1'b0;
      out_en     <= 1'b1;
      commit_err <= 1'b0;
      bank_sel   <= 1'b0;
      swap_cnt   <= '0;
    end else begin
      cfg_ready  <= (state_nx == IDLE);
      busy       <= (state_nx != IDLE);
      fir_flush  <= (state_nx == SWAP);
      out_en     <= (state_nx != SWAP) && (state_nx != FILL);
      commit_err <= commit && (state != IDLE);
      if (state == SWAP) begin
        bank_sel <= ~bank_sel;
        swap_cnt <= swap_cnt + 8'd1;
      end
    end
  end

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .COEF_W(COEF_W),
    .AW    (AW)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en_c),
    .wr_bank(~bank_sel),
    .wr_addr(cfg_addr),
    .wr_data(cfg_data),
    .cp_en  (cp_en_c),
    .cp_src (bank_sel),
    .cp_addr(cp_idx[AW-1:0]),
    .rd_bank(bank_sel),
    .rd_addr(coef_rd_addr),
    .rd_data(coef_rd_data)
  );

endmodule

// File: tb/tb_fir_coef_sched.sv
// Directed bench for fir_coef_sched with NTAPS=8, COEF_W=16.
module tb_fir_coef_sched;

  localparam int unsigned NT = 8;
  localparam int unsigned CWD = 16;
  localparam int unsigned AWD = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [AWD-1:0] cfg_addr;
  logic [CWD-1:0] cfg_data;
  logic           commit;
  logic           commit_err;
  logic           in_valid;
  logic [AWD-1:0] coef_rd_addr;
  logic [CWD-1:0] coef_rd_data;
  logic           fir_flush;
  logic           out_en;
  logic           bank_sel;
  logic           busy;
  logic [7:0]     swap_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_coef_sched #(.NTAPS(NT), .COEF_W(CWD), .AW(AWD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .commit      (commit),
    .commit_err  (commit_err),
    .in_valid    (in_valid),
    .coef_rd_addr(coef_rd_addr),
    .coef_rd_data(coef_rd_data),
    .fir_flush   (fir_flush),
    .out_en      (out_en),
    .bank_sel    (bank_sel),
    .busy        (busy),
    .swap_cnt    (swap_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_out_en"}, 32'(out_en), 32'd1);
    chk({tag, "_flush"}, 32'(fir_flush), 32'd0);
  endtask

  // Read all taps of the active bank and compare with the expected table.
  task automatic chk_bank(input string tag, input logic [CWD-1:0] exp [NT]);
    for (int k = 0; k < int'(NT); k++) begin
      coef_rd_addr = AWD'(k);
      step();
      chk($sformatf("%s_tap%0d", tag, k), 32'(coef_rd_data), 32'(exp[k]));
    end
  endtask

  // Commit, then run a swap with in_valid high every cycle until IDLE.
  task automatic fast_swap();
    commit = 1'b1;
    step();
    commit = 1'b0;
    in_valid = 1'b1;
    step();
    repeat (NT + 1) step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [CWD-1:0] exp_a [NT];
    logic [CWD-1:0] exp_b [NT];
    logic [CWD-1:0] exp_z [NT];

    for (int k = 0; k < int'(NT); k++) begin
      exp_a[k] = CWD'(16'h0100 + k);
      exp_b[k] = CWD'(16'h0100 + k);
      exp_z[k] = '0;
    end
    exp_b[3] = 16'h7FFF;

    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    commit = 1'b0;
    in_valid = 1'b0;
    coef_rd_addr = '0;
    repeat (3) step();

    // Reset values
    chk_idle_outputs("rst");
    chk("rst_err", 32'(commit_err), 32'd0);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    chk("rst_rd", 32'(coef_rd_data), 32'd0);
    rst_n = 1'b1;
    step();

    // Scenario 1: full shadow load and swap
    for (int k = 0; k < int'(NT); k++) begin
      cfg_valid = 1'b1;
      cfg_addr = AWD'(k);
      cfg_data = CWD'(16'h0100 + k);
      step();
    end
    cfg_valid = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_ready", 32'(cfg_ready), 32'd0);
    chk("arm_out_en", 32'(out_en), 32'd1);
    in_valid = 1'b1;
    step();
    chk("swap_flush", 32'(fir_flush), 32'd1);
    chk("swap_out_en", 32'(out_en), 32'd0);
    chk("swap_bank_sel_old", 32'(bank_sel), 32'd0);
    step();
    chk("fill1_flush", 32'(fir_flush), 32'd0);
    chk("fill1_bank_sel", 32'(bank_sel), 32'd1);
    chk("fill1_swap_cnt", 32'(swap_cnt), 32'd1);
    for (int i = 2; i <= int'(NT); i++) begin
      step();
      chk($sformatf("fill%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("fill%0d_out_en", i), 32'(out_en), 32'd0);
      chk($sformatf("fill%0d_flush", i), 32'(fir_flush), 32'd0);
    end
    step();
    in_valid = 1'b0;
    chk_idle_outputs("s1_idle");
    chk_bank("s1", exp_a);

    // Scenario 2: partial update of tap 3 with simultaneous commit
    cfg_valid = 1'b1;
    cfg_addr = 3'd3;
    cfg_data = 16'h7FFF;
    commit = 1'b1;
    step();
    cfg_valid = 1'b0;
    commit = 1'b0;
    in_valid = 1'b1;
    step();
    repeat (NT + 1) step();
    in_valid = 1'b0;
    chk_idle_outputs("s2_idle");
    chk("s2_bank_sel", 32'(bank_sel), 32'd0);
    chk("s2_swap_cnt", 32'(swap_cnt), 32'd2);
    chk_bank("s2", exp_b);

    // Scenario 3: ARM waits for the sample boundary
    commit = 1'b1;
    step();
    commit = 1'b0;
    repeat (20) step();
    chk("s3_busy", 32'(busy), 32'd1);
    chk("s3_bank_sel", 32'(bank_sel), 32'd0);
    chk("s3_out_en", 32'(out_en), 32'd1);
    chk("s3_flush", 32'(fir_flush), 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("s3_swap_flush", 32'(fir_flush), 32'd1);
    step();
    chk("s3_bank_sel_new", 32'(bank_sel), 32'd1);
    chk("s3_swap_cnt", 32'(swap_cnt), 32'd3);

    // Scenario 4/5: sparse strobes in FILL, plus commit and write attempts
    for (int s = 1; s <= int'(NT); s++) begin
      for (int j = 0; j < 3; j++) begin
        if (s == 2 && j == 0) begin
          commit = 1'b1;
          cfg_valid = 1'b1;
          cfg_addr = 3'd0;
          cfg_data = 16'hDEAD;
        end
        step();
        if (s == 2 && j == 0) begin
          commit = 1'b0;
          cfg_valid = 1'b0;
          chk("s5_commit_err", 32'(commit_err), 32'd1);
          chk("s5_ready", 32'(cfg_ready), 32'd0);
        end
        if (s == 2 && j == 1) chk("s5_commit_err_clear", 32'(commit_err), 32'd0);
      end
      chk($sformatf("s4_out_en_pre%0d", s), 32'(out_en), 32'd0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (s < int'(NT)) chk($sformatf("s4_out_en_post%0d", s), 32'(out_en), 32'd0);
    end
    chk_idle_outputs("s4_idle");
    chk("s5_swap_cnt", 32'(swap_cnt), 32'd3);

    // The blocked 0xDEAD write must not have reached bank 0
    fast_swap();
    chk("s5b_bank_sel", 32'(bank_sel), 32'd0);
    chk("s5b_swap_cnt", 32'(swap_cnt), 32'd4);
    chk_bank("s5b", exp_b);

    // Scenario 6: asynchronous reset in the middle of FILL
    coef_rd_addr = 3'd3;
    commit = 1'b1;
    step();
    commit = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    step();
    chk("s6_pre_busy", 32'(busy), 32'd1);
    chk("s6_pre_bank_sel", 32'(bank_sel), 32'd1);
    chk("s6_pre_rd", 32'(coef_rd_data), 32'h7FFF);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("s6_rst");
    chk("s6_rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("s6_rst_swap_cnt", 32'(swap_cnt), 32'd0);
    chk("s6_rst_rd", 32'(coef_rd_data), 32'd0);
    chk("s6_rst_err", 32'(commit_err), 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_bank("s6_post", exp_z);
    chk_idle_outputs("s6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_coef_sched.md
# fir_coef_sched

Coefficient bank scheduler for the `fir_top` datapath.
- Holds two banks of FIR tap coefficients: one active bank drives the taps, one shadow bank accepts configuration writes from the I2C register slave.
- Swaps banks glitch-free on a sample boundary, then flushes the FIR delay line and masks the output while the filter refills.
- Sits between the I2C register file and the FIR multiply-accumulate array inside `fir_top`.

## Interface
Parameters:
- `NTAPS`, 32, number of FIR taps (power of two, ≥4)
- `COEF_W`, 16, signed coefficient width
- `AW`, $clog2(NTAPS), tap address width

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_valid`  in  1  shadow-bank write request
- `cfg_ready`  out  1  write accepted when both `cfg_valid` and `cfg_ready` are high
- `cfg_addr`  in  AW  shadow tap index
- `cfg_data`  in  COEF_W  shadow coefficient value
- `commit`  in  1  single-cycle pulse requesting a bank swap
- `commit_err`  out  1  one-cycle pulse: `commit` arrived outside IDLE and was ignored
- `in_valid`  in  1  FIR input sample strobe; marks the sample boundary
- `coef_rd_addr`  in  AW  tap read address from the MAC array
- `coef_rd_data`  out  COEF_W  active-bank coefficient, registered
- `fir_flush`  out  1  clear the FIR delay line
- `out_en`  out  1  FIR output valid mask
- `bank_sel`  out  1  index of the active bank
- `busy`  out  1  high whenever the state is not IDLE
- `swap_cnt`  out  8  count of completed swaps, wraps modulo 256

## Operation
- Storage is `bank[2][NTAPS]` × COEF_W. The shadow bank is always `~bank_sel`.
- Reset values: every coefficient 0, `bank_sel`=0, `swap_cnt`=0, state IDLE, `coef_rd_data`=0, `fir_flush`=0, `commit_err`=0, `out_en`=1, `cfg_ready`=1, `busy`=0.
- FSM states and transitions:
  - **IDLE**: `cfg_ready`=1. An accepted write stores `cfg_data` to `bank[~bank_sel][cfg_addr]`. `commit` → ARM.
  - **ARM**: waits for `in_valid`=1 → SWAP. `cfg_ready`=0.
  - **SWAP**: one cycle. `fir_flush`=1 and `out_en`=0. On exit, `bank_sel` toggles, `swap_cnt` increments, and the sample and copy counters clear → FILL.
  - **FILL**: `out_en`=0.
    - Sample counter counts `in_valid` strobes.
    - Copy engine writes `bank[~bank_sel][k] <= bank[bank_sel][k]` for k=0..NTAPS-1, one tap per cycle. This makes the new shadow equal to the new active bank, so partial updates are allowed afterwards.
    - Exits → IDLE when sample count = NTAPS and copy index = NTAPS.
- `coef_rd_data <= bank[bank_sel][coef_rd_addr]` every cycle, in every state.
- Simultaneous `cfg_valid`, `cfg_ready` and `commit` in IDLE: the write lands first, and the swap includes it.
- `commit` in ARM, SWAP or FILL: ignored, `commit_err` pulses one cycle, state is unchanged.
- `cfg_valid` while `cfg_ready`=0: not accepted. The requester holds its request.
- `rst_n` asserted mid-ARM or mid-FILL: immediate return to reset values. Any partial copy is discarded.
- Counters are AW+1 bits wide so that the value NTAPS is representable. `swap_cnt` wraps 255→0.

## Timing
- `commit` sampled high at edge t: `busy`=1 and `cfg_ready`=0 from t+1.
- First `in_valid` in ARM at edge u: SWAP occupies cycle u+1. `bank_sel` holds its new value from cycle u+2.
- The coefficient read latency is 1 cycle. A read issued during SWAP returns the old bank. A read issued in the first FILL cycle returns the new bank.
- Minimum SWAP→IDLE time is NTAPS cycles (`in_valid` high every cycle). IDLE is reached one cycle after both exit conditions hold.
- `out_en` rises in the first IDLE cycle.
- All outputs are registered or decoded from registered state; none are combinational from inputs.

## Structure
- Shared package `fir_pkg` holds the FSM state enum (IDLE/ARM/SWAP/FILL), `NTAPS`/`COEF_W` defaults, and the coefficient type.
- One sub-module, `fir_coef_bank`: the two-bank register array with a shadow write port, a copy port and a registered read port. The FSM and counters stay in `fir_coef_sched`.

## Test plan
All scenarios use NTAPS=8 and COEF_W=16.
- Write shadow taps 0..7 = 0x0100..0x0107, commit, `in_valid` every cycle → `fir_flush` for exactly 1 cycle, `bank_sel`=1, reads return 0x0100..0x0107, `swap_cnt`=1, IDLE 8 cycles after SWAP.
- After the first swap, write only tap 3 = 0x7FFF and commit → active bank = 0x0100,0x0101,0x0102,0x7FFF,0x0104..0x0107, which proves the copy engine.
- Commit with `in_valid` held low for 20 cycles → state stays ARM, `bank_sel` unchanged, `out_en`=1. `in_valid` pulse → SWAP next cycle.
- `in_valid` every 4th cycle during FILL → `out_en` stays low until the 8th strobe, then rises one cycle later.
- Commit during FILL → `commit_err` one-cycle pulse, `swap_cnt` unchanged. `cfg_valid` during FILL → no write occurs (`cfg_ready`=0).
- `rst_n` low mid-FILL → all outputs return to reset values in the same cycle, and reads return 0.
